// File: rtl/axis_ingress_framer_if.sv
// AXI-stream style beat bundle shared by the ingress and egress sides
// of the framer. The sop sideband is only driven on the egress side.
interface axis_ingress_framer_if #(
   parameter int DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic              last;
   logic              sop;

   modport master (
      output valid,
      output data,
      output last,
      output sop,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/axis_ingress_framer.sv
// Ingress framer: buffers DMA beats in a FIFO, regenerates SOP from
// TLAST, truncates overlong frames and tracks egress statistics.
module axis_ingress_framer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int MAX_LEN = 223,
   parameter int LVL_W   = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axis_ingress_framer_if.slave  s_axis,
   axis_ingress_framer_if.master m_axis,
   input  logic                 flush,
   input  logic                 err_clr,
   output logic [LVL_W-1:0]     level,
   output logic [15:0]          frame_cnt,
   output logic [15:0]          underrun_cnt,
   output logic                 err_overlong
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] INFRAME = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              sop;
   } ent_t;

   ent_t              mem [DEPTH];
   ent_t              wr_ent;
   ent_t              rd_ent;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [15:0]       cnt;
   logic [15:0]       cnt_nxt;
   logic              full;
   logic              empty;
   logic              acc;
   logic              wr_en;
   logic              rd_en;
   logic              ovl_set;
   logic              in_frame;

   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);

   assign s_axis.ready = !full && !flush;
   assign acc          = s_axis.valid && s_axis.ready;

   // Egress is hidden during a flush so no beat is consumed that
   // the pointer reset is about to discard.
   assign rd_ent       = mem[rd_ptr];
   assign m_axis.valid = !empty && !flush;
   assign m_axis.data  = empty ? '0 : rd_ent.data;
   assign m_axis.last  = !empty && rd_ent.last;
   assign m_axis.sop   = !empty && rd_ent.sop;
   assign rd_en        = m_axis.valid && m_axis.ready;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      ovl_set   = 1'b0;
      wr_ent    = '{data: s_axis.data, last: s_axis.last, sop: 1'b0};
      if (acc) begin
         case (state)
            IDLE: begin
               wr_en      = 1'b1;
               wr_ent.sop = 1'b1;
               cnt_nxt    = 16'd1;
               if (s_axis.last || MAX_L == 16'd1) begin
                  wr_ent.last = 1'b1;
                  ovl_set     = !s_axis.last;
               end else begin
                  state_nxt = INFRAME;
               end
            end
            INFRAME: begin
               wr_en   = 1'b1;
               cnt_nxt = cnt + 16'd1;
               if (s_axis.last) begin
                  state_nxt = IDLE;
               end else if (cnt_nxt == MAX_L) begin
                  wr_ent.last = 1'b1;
                  ovl_set     = 1'b1;
                  state_nxt   = DISCARD;
               end
            end
            DISCARD: begin
               if (s_axis.last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (flush) begin
         state <= (state == INFRAME) ? DISCARD : IDLE;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Storage has no reset; valid is derived from the level only.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_ent;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !rd_en)      level <= level + LVL_W'(1);
         else if (!wr_en && rd_en) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt    <= '0;
         underrun_cnt <= '0;
         in_frame     <= 1'b0;
         err_overlong <= 1'b0;
      end else begin
         err_overlong <= ovl_set || (err_overlong && !err_clr);
         if (rd_en && m_axis.last) frame_cnt <= frame_cnt + 16'd1;
         if (in_frame && m_axis.ready && !m_axis.valid && !flush &&
             underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
         if (flush) begin
            in_frame <= 1'b0;
         end else if (rd_en) begin
            if (m_axis.last)     in_frame <= 1'b0;
            else if (m_axis.sop) in_frame <= 1'b1;
         end
      end
   end

endmodule
